// File: rtl/mbgd_hy_sched.sv
// H-Y reduction sequencer: pairs h/y rows, fires the subtractor, streams differences.
// Optional abort port pair enabled by defining MBGD_HY_ABORT_EN.
module mbgd_hy_sched #(
  parameter int N      = 8,
  parameter int DW     = 8,
  parameter int ROW_AW = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ROW_AW-1:0] batch_rows,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [DW*N-1:0]   h_data,
  input  logic              y_valid,
  output logic              y_ready,
  input  logic [DW*N-1:0]   y_data,
  output logic              red_en,
  output logic [DW*N-1:0]   red_inp1,
  output logic [DW*N-1:0]   red_inp2,
  input  logic [DW*N-1:0]   red_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW*N-1:0]   out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
`ifdef MBGD_HY_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [ROW_AW-1:0] rows_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_OUT,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [ROW_AW-1:0] rows_total;
  logic              abort_hit;
  logic              take;
  logic              out_fire;
  logic              last_row;
  logic              go;

`ifdef MBGD_HY_ABORT_EN
  assign abort_hit = abort & (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign go       = (state == ST_IDLE) & start;
  assign take     = (state == ST_LOAD) & h_valid
                  & y_valid & ~abort_hit;
  assign last_row = rows_done
                  == (rows_total - ROW_AW'(1));
  assign out_fire = (state == ST_OUT) & out_ready
                  & ~abort_hit;

  assign h_ready   = take;
  assign y_ready   = take;
  assign red_en    = (state == ST_FIRE);
  assign out_valid = (state == ST_OUT);
  assign out_data  = red_result;
  assign out_last  = out_valid & last_row;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (batch_rows == '0) state_d = ST_DONE;
          else                  state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (take) state_d = ST_FIRE;
      end
      ST_FIRE: state_d = ST_OUT;
      ST_OUT: begin
        if (out_fire) begin
          if (last_row) state_d = ST_DONE;
          else          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // abort beats any completion on the same edge
    if (abort_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rows_total <= '0;
      rows_done  <= '0;
    end else if (go) begin
      rows_total <= batch_rows;
      rows_done  <= '0;
    end else if (out_fire) begin
      rows_done  <= rows_done + ROW_AW'(1);
    end
  end

  // operands stay put so the subtractor output holds through OUT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      red_inp1 <= '0;
      red_inp2 <= '0;
    end else if (take) begin
      red_inp1 <= h_data;
      red_inp2 <= y_data;
    end
  end

`ifdef MBGD_HY_ABORT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) aborted <= 1'b0;
    else         aborted <= abort_hit;
  end
`endif

endmodule

// File: tb/tb_mbgd_hy_sched.sv
// Bench for mbgd_hy_sched: directed scenarios plus random traffic
// against a transaction-level model with a registered subtractor stand-in.
module tb_mbgd_hy_sched;

  localparam int N      = 8;
  localparam int DW     = 8;
  localparam int ROW_AW = 8;
  localparam int W      = DW * N;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [ROW_AW-1:0] batch_rows;
  logic              h_valid;
  logic              h_ready;
  logic [W-1:0]      h_data;
  logic              y_valid;
  logic              y_ready;
  logic [W-1:0]      y_data;
  logic              red_en;
  logic [W-1:0]      red_inp1;
  logic [W-1:0]      red_inp2;
  logic [W-1:0]      red_result;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [ROW_AW-1:0] rows_done;
`ifdef MBGD_HY_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  int total = 0;
  int bad   = 0;

  mbgd_hy_sched #(.N(N), .DW(DW), .ROW_AW(ROW_AW)) dut (
    .clk(clk), .resetn(resetn),
    .start(start), .batch_rows(batch_rows),
    .h_valid(h_valid), .h_ready(h_ready),
    .h_data(h_data),
    .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data),
    .red_en(red_en), .red_inp1(red_inp1),
    .red_inp2(red_inp2), .red_result(red_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done),
`ifdef MBGD_HY_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sub_row(
    input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*DW +: DW] = a[i*DW +: DW] - b[i*DW +: DW];
    return r;
  endfunction

  // stand-in for the external registered subtractor
  always @(posedge clk or negedge resetn) begin
    if (!resetn)     red_result <= '0;
    else if (red_en) red_result <= sub_row(red_inp1, red_inp2);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // transaction model: batch open, row age since pairing, rows delivered
  bit         busy_m;
  bit         done_now;
  bit         aborted_m;
  int         inflight;
  int         done_m;
  int         total_m;
  bit [W-1:0] last_h;
  bit [W-1:0] last_y;
  bit [W-1:0] exp_row;
  int         n_red_en;

  function automatic bit abort_now();
`ifdef MBGD_HY_ABORT_EN
    return abort;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_m = 0; done_now = 0; aborted_m = 0;
      inflight = 0; done_m = 0; total_m = 0;
      last_h = '0; last_y = '0;
    end else begin
      aborted_m = 0;
      if (abort_now() && busy_m) begin
        busy_m = 0; done_now = 0; inflight = 0;
        aborted_m = 1;
      end else if (done_now) begin
        done_now = 0; busy_m = 0;
      end else if (!busy_m) begin
        if (start) begin
          total_m = int'(batch_rows);
          done_m = 0;
          busy_m = 1;
          if (total_m == 0) done_now = 1;
        end
      end else if (inflight == 0) begin
        if (h_valid && y_valid) begin
          last_h = h_data;
          last_y = y_data;
          exp_row = sub_row(h_data, y_data);
          inflight = 1;
        end
      end else if (inflight == 1) begin
        inflight = 2;
      end else if (out_ready) begin
        done_m++;
        inflight = 0;
        if (done_m == total_m) done_now = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit rdy;
    rdy = busy_m && !done_now && inflight == 0
       && h_valid && y_valid && !abort_now();
    if (red_en) n_red_en++;
    chk("h_ready", h_ready, rdy);
    chk("y_ready", y_ready, rdy);
    chk("red_en", red_en, inflight == 1);
    chk("out_valid", out_valid, inflight == 2);
    chk("out_last", out_last,
        inflight == 2 && done_m == total_m - 1);
    chk("busy", busy, busy_m);
    chk("done", done, done_now);
    chk("rows_done", rows_done, done_m);
    chk("red_inp1", red_inp1, last_h);
    chk("red_inp2", red_inp2, last_y);
    if (inflight == 2) chk("out_data", out_data, exp_row);
`ifdef MBGD_HY_ABORT_EN
    chk("aborted", aborted, aborted_m);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int n);
    batch_rows = ROW_AW'(n);
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy_m || done_now) && k < budget) begin
      cyc();
      k++;
    end
    chk("idle_timeout", busy_m, 0);
  endtask

  task automatic wait_age(input int age, input int budget);
    int k = 0;
    while (inflight != age && k < budget) begin
      cyc();
      k++;
    end
    chk("age_timeout", inflight, age);
  endtask

  initial begin
    logic [W-1:0] held;
    resetn = 0; start = 0; batch_rows = '0;
    h_valid = 0; y_valid = 0; out_ready = 0;
    h_data = '0; y_data = '0;
`ifdef MBGD_HY_ABORT_EN
    abort = 0;
`endif
    repeat (3) cyc();
    resetn = 1;
    cyc();

    // three-row batch, lane i: h=10(i+1), y=3+2i
    for (int i = 0; i < N; i++) begin
      h_data[i*DW +: DW] = DW'(10 * (i + 1));
      y_data[i*DW +: DW] = DW'(3 + 2 * i);
    end
    h_valid = 1; y_valid = 1; out_ready = 1;
    kick(3);
    wait_idle(60);
    chk("lane0_row3", red_result[DW-1:0], 7);
    chk("rows_done_3", rows_done, 3);

    // lone h_valid held off for 5 cycles
    n_red_en = 0;
    y_valid = 0;
    kick(1);
    repeat (5) cyc();
    y_valid = 1;
    wait_idle(30);
    chk("red_en_once", n_red_en, 1);

    // out_ready stalled for 10 cycles in OUT
    n_red_en = 0;
    out_ready = 0;
    kick(1);
    wait_age(2, 20);
    held = out_data;
    repeat (10) cyc();
    chk("stall_data", out_data, held);
    chk("stall_rows", rows_done, 0);
    out_ready = 1;
    wait_idle(20);
    chk("stall_red_en", n_red_en, 1);

    // empty batch plus a start while busy
    h_valid = 0; y_valid = 0;
    kick(0);
    start = 1;
    cyc();
    start = 0;
    wait_idle(10);
    chk("empty_rows", rows_done, 0);

    // per-lane wrap 0x00 - 0x01
    h_data = '0;
    y_data = {N{8'h01}};
    h_valid = 1; y_valid = 1;
    kick(1);
    wait_age(2, 20);
    chk("wrap_lane0", out_data[DW-1:0], 8'hFF);
    wait_idle(20);

    // reset during FIRE
    kick(2);
    wait_age(1, 20);
    resetn = 0;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    resetn = 1;
    cyc();

`ifdef MBGD_HY_ABORT_EN
    // abort in OUT with two rows delivered
    kick(4);
    while (!(done_m == 2 && inflight == 2) && busy_m)
      cyc();
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_aborted", aborted, 1);
    chk("abort_rows", rows_done, 2);
    chk("abort_busy", busy, 0);
    cyc();
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      batch_rows = ROW_AW'($urandom_range(0, 5));
      h_valid = ($urandom_range(0, 9) < 7);
      y_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      h_data = {$urandom, $urandom};
      y_data = {$urandom, $urandom};
`ifdef MBGD_HY_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
      cyc();
    end
    start = 0;
`ifdef MBGD_HY_ABORT_EN
    abort = 0;
`endif
    h_valid = 1; y_valid = 1; out_ready = 1;
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
